// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//
// Contents:
//   tx_state_e      - transmitter frame state
//   UART_DATA_BITS  - data bits per frame (LSB first)
//   UART_START_LVL  - line level of the start bit
//   UART_STOP_LVL   - line level of stop bits and of the idle line
//   uart_parity()   - parity bit for a data byte; odd = 1 inverts the even result
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_engine_fifo.sv
// Generic synchronous FIFO (first-word fall-through read port).
//
// Parameters:
//   data_size   - width of each entry
//   buffer_size - number of entries (power of 2, at least 2)
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (flushes the FIFO)
//   wr_en      - write request; ignored while full
//   wr_data    - entry to write
//   rd_en      - read request (pops the head); ignored while empty
//   rd_data    - current head entry, valid while !empty
//   full       - no free entries
//   empty      - no stored entries
module uart_tx_engine_fifo #(
  parameter int data_size   = 8,
  parameter int buffer_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [data_size-1:0] wr_data,
  input  logic                 rd_en,
  output logic [data_size-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(buffer_size);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [data_size-1:0] mem_q [buffer_size];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: a flushed FIFO never presents its contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises bytes from the TX FIFO onto the tx line.
// Frame: start bit (0), 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All state changes and tx updates happen only on clk edges where baud_tick = 1.
//
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   baud_tick     - one-clk strobe per bit period (clock enable)
//   enable        - allows new frames to start
//   cts_n         - clear-to-send, active-low, sampled only when a frame starts
//   tx            - registered serial output, idles high
//   txfifo_data   - byte to enqueue
//   txfifo_valid  - enqueue request (taken when txfifo_ready)
//   txfifo_ready  - FIFO can accept a byte (!txfifo_full)
//   txfifo_full   - FIFO full
//   txfifo_empty  - FIFO empty
//   busy          - frame in progress
//   tx_done       - one-clk pulse after the tick that ends the last stop bit
//   irq_en        - interrupt mask
//   tx_irq        - irq_en & txfifo_empty & !busy
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       enable,
  input  logic       cts_n,
  output logic       tx,
  input  logic [7:0] txfifo_data,
  input  logic       txfifo_valid,
  output logic       txfifo_ready,
  output logic       txfifo_full,
  output logic       txfifo_empty,
  output logic       busy,
  output logic       tx_done,
  input  logic       irq_en,
  output logic       tx_irq
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic                      tx_q, tx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      parity_q, parity_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      tx_done_q, tx_done_d;

  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       start_ok;
  logic       last_stop;
  logic       launch;

  uart_tx_engine_fifo #(
    .data_size  (8),
    .buffer_size(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (txfifo_valid),
    .wr_data(txfifo_data),
    .rd_en  (fifo_rd_en),
    .rd_data(fifo_rd_data),
    .full   (txfifo_full),
    .empty  (txfifo_empty)
  );

  assign txfifo_ready = ~txfifo_full;
  assign tx           = tx_q;
  assign busy         = (state_q != TX_IDLE);
  assign tx_done      = tx_done_q;
  assign tx_irq       = irq_en & txfifo_empty & ~busy;

  // Next-state logic. A new frame can be launched from IDLE or from the
  // tick that ends the last stop bit, which gives gap-free back-to-back frames.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    parity_d   = parity_q;
    stop_cnt_d = stop_cnt_q;
    tx_done_d  = 1'b0;
    fifo_rd_en = 1'b0;
    launch     = 1'b0;

    start_ok  = ~txfifo_empty & enable & ~cts_n;
    last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;

    if (baud_tick) begin
      case (state_q)
        TX_IDLE: begin
          if (start_ok) launch = 1'b1;
          else          tx_d   = UART_STOP_LVL;
        end
        TX_START: begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = TX_DATA;
        end
        TX_DATA: begin
          if (cnt_q != LAST_BIT) begin
            cnt_d = cnt_q + 3'd1;
            tx_d  = shift_q[cnt_q + 3'd1];
          end else if (PARITY_EN != 0) begin
            tx_d    = parity_q;
            state_d = TX_PARITY;
          end else begin
            tx_d       = UART_STOP_LVL;
            stop_cnt_d = 1'b0;
            state_d    = TX_STOP;
          end
        end
        TX_PARITY: begin
          tx_d       = UART_STOP_LVL;
          stop_cnt_d = 1'b0;
          state_d    = TX_STOP;
        end
        TX_STOP: begin
          if (!last_stop) begin
            stop_cnt_d = 1'b1;
          end else begin
            tx_done_d = 1'b1;
            if (start_ok) begin
              launch = 1'b1;
            end else begin
              tx_d    = UART_STOP_LVL;
              state_d = TX_IDLE;
            end
          end
        end
        default: begin
          tx_d    = UART_STOP_LVL;
          state_d = TX_IDLE;
        end
      endcase
    end

    // Frame launch: pop the head into the shift register and emit the start bit.
    if (launch) begin
      fifo_rd_en = 1'b1;
      shift_d    = fifo_rd_data;
      parity_d   = uart_parity(fifo_rd_data, (PARITY_ODD != 0));
      tx_d       = UART_START_LVL;
      state_d    = TX_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      tx_q       <= UART_STOP_LVL;
      shift_q    <= '0;
      cnt_q      <= '0;
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      parity_q   <= parity_d;
      stop_cnt_q <= stop_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine.
// Four instances share clock, reset, baud and control inputs but have their own
// enqueue strobes:
//   0: default (even parity, 1 stop)   1: odd parity
//   2: no parity                       3: parity, 2 stop bits
// A baud period is two clk cycles; tx is captured on the falling edge after
// each tick edge.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic       enable;
  logic       cts_n;
  logic       irq_en;
  logic [7:0] txfifo_data;
  logic [3:0] valid_v;
  logic [3:0] tx_v, ready_v, full_v, empty_v, busy_v, done_v, irq_v;

  int compared   = 0;
  int mismatched = 0;

  int         done_cnt [4];
  int         base_done[4];
  logic [3:0] cap_v [128];
  int         cap_n;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (done_v[i]) done_cnt[i]++;
  end

  uart_tx_engine dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .enable(enable), .cts_n(cts_n),
    .tx(tx_v[0]), .txfifo_data(txfifo_data), .txfifo_valid(valid_v[0]),
    .txfifo_ready(ready_v[0]), .txfifo_full(full_v[0]), .txfifo_empty(empty_v[0]),
    .busy(busy_v[0]), .tx_done(done_v[0]), .irq_en(irq_en), .tx_irq(irq_v[0])
  );

  uart_tx_engine #(.PARITY_ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .enable(enable), .cts_n(cts_n),
    .tx(tx_v[1]), .txfifo_data(txfifo_data), .txfifo_valid(valid_v[1]),
    .txfifo_ready(ready_v[1]), .txfifo_full(full_v[1]), .txfifo_empty(empty_v[1]),
    .busy(busy_v[1]), .tx_done(done_v[1]), .irq_en(irq_en), .tx_irq(irq_v[1])
  );

  uart_tx_engine #(.PARITY_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .enable(enable), .cts_n(cts_n),
    .tx(tx_v[2]), .txfifo_data(txfifo_data), .txfifo_valid(valid_v[2]),
    .txfifo_ready(ready_v[2]), .txfifo_full(full_v[2]), .txfifo_empty(empty_v[2]),
    .busy(busy_v[2]), .tx_done(done_v[2]), .irq_en(irq_en), .tx_irq(irq_v[2])
  );

  uart_tx_engine #(.STOP_BITS(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .enable(enable), .cts_n(cts_n),
    .tx(tx_v[3]), .txfifo_data(txfifo_data), .txfifo_valid(valid_v[3]),
    .txfifo_ready(ready_v[3]), .txfifo_full(full_v[3]), .txfifo_empty(empty_v[3]),
    .busy(busy_v[3]), .tx_done(done_v[3]), .irq_en(irq_en), .tx_irq(irq_v[3])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs n baud periods, capturing tx of every instance after each tick.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) baud_tick = 1'b1;
      @(negedge clk) baud_tick = 1'b0;
      if (cap_n < 128) begin
        cap_v[cap_n] = tx_v;
        cap_n++;
      end
    end
    @(negedge clk);
  endtask

  task automatic pushByte(input logic [3:0] which, input logic [7:0] d);
    @(negedge clk);
    valid_v     = which;
    txfifo_data = d;
    @(negedge clk);
    valid_v     = 4'h0;
  endtask

  task automatic snapDone();
    for (int i = 0; i < 4; i++) base_done[i] = done_cnt[i];
  endtask

  function automatic logic [15:0] capBits(input int dut, input int first, input int len);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[k] = cap_v[first + k][dut];
    return r;
  endfunction

  // Expected line levels, bit k = k-th bit period of the frame.
  function automatic logic [15:0] expFrame(input logic [7:0] d, input bit par_en,
                                           input bit odd, input int stops);
    logic [15:0] r;
    int          k;
    r      = '0;
    r[8:1] = d;
    k      = 9;
    if (par_en) begin
      r[9] = (^d) ^ odd;
      k    = 10;
    end
    for (int s = 0; s < stops; s++) r[k + s] = 1'b1;
    return r;
  endfunction

  initial begin
    rst_n       = 1'b0;
    baud_tick   = 1'b0;
    enable      = 1'b0;
    cts_n       = 1'b1;
    irq_en      = 1'b0;
    valid_v     = 4'h0;
    txfifo_data = 8'h00;
    cap_n       = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx",    32'(tx_v),    32'hF);
    checkOutput("rst_busy",  32'(busy_v),  32'h0);
    checkOutput("rst_done",  32'(done_v),  32'h0);
    checkOutput("rst_irq",   32'(irq_v),   32'h0);
    checkOutput("rst_empty", 32'(empty_v), 32'hF);
    checkOutput("rst_full",  32'(full_v),  32'h0);
    checkOutput("rst_ready", 32'(ready_v), 32'hF);
    rst_n = 1'b1;

    // Single 0x55 frame, even parity
    irq_en = 1'b1;
    enable = 1'b1;
    cts_n  = 1'b0;
    @(negedge clk);
    checkOutput("irq_idle_empty", 32'(irq_v[0]), 32'h1);
    pushByte(4'b0001, 8'h55);
    checkOutput("irq_pending", 32'(irq_v[0]), 32'h0);
    cap_n = 0;
    snapDone();
    applyStimulus(11);
    checkOutput("frame_55",      32'(capBits(0, 0, 11)), 32'h4AA);
    checkOutput("busy_in_stop",  32'(busy_v[0]), 32'h1);
    checkOutput("done_early_55", done_cnt[0] - base_done[0], 0);
    applyStimulus(1);
    checkOutput("done_55",     done_cnt[0] - base_done[0], 1);
    checkOutput("idle_tx_55",  32'(tx_v[0]), 32'h1);
    checkOutput("idle_busy",   32'(busy_v[0]), 32'h0);
    checkOutput("irq_after",   32'(irq_v[0]), 32'h1);

    // 0x01 on all parameter variants
    pushByte(4'b1111, 8'h01);
    cap_n = 0;
    snapDone();
    applyStimulus(10);
    checkOutput("np_done_t10", done_cnt[2] - base_done[2], 0);
    applyStimulus(1);
    checkOutput("np_done_t11",   done_cnt[2] - base_done[2], 1);
    checkOutput("even_done_t11", done_cnt[0] - base_done[0], 0);
    applyStimulus(1);
    checkOutput("even_done_t12", done_cnt[0] - base_done[0], 1);
    checkOutput("odd_done_t12",  done_cnt[1] - base_done[1], 1);
    checkOutput("2stop_done_t12", done_cnt[3] - base_done[3], 0);
    applyStimulus(1);
    checkOutput("2stop_done_t13", done_cnt[3] - base_done[3], 1);
    checkOutput("frame_01_even",  32'(capBits(0, 0, 11)), 32'h602);
    checkOutput("frame_01_odd",   32'(capBits(1, 0, 11)), 32'h402);
    checkOutput("frame_01_nopar", 32'(capBits(2, 0, 10)), 32'h202);
    checkOutput("frame_01_2stop", 32'(capBits(3, 0, 12)), 32'hE02);

    // Back-to-back 0xA5, 0x3C
    pushByte(4'b0001, 8'hA5);
    pushByte(4'b0001, 8'h3C);
    cap_n = 0;
    snapDone();
    applyStimulus(22);
    checkOutput("b2b_frame_A5", 32'(capBits(0, 0, 11)),  32'(expFrame(8'hA5, 1'b1, 1'b0, 1)));
    checkOutput("b2b_frame_3C", 32'(capBits(0, 11, 11)), 32'(expFrame(8'h3C, 1'b1, 1'b0, 1)));
    checkOutput("b2b_no_gap",   32'(cap_v[11][0]), 32'h0);
    checkOutput("b2b_done_mid", done_cnt[0] - base_done[0], 1);
    applyStimulus(1);
    checkOutput("b2b_done_end", done_cnt[0] - base_done[0], 2);
    checkOutput("b2b_busy_end", 32'(busy_v[0]), 32'h0);

    // Flow control with cts_n
    cts_n = 1'b1;
    pushByte(4'b0001, 8'h7E);
    cap_n = 0;
    snapDone();
    applyStimulus(3);
    checkOutput("cts_hold_tx",   32'(capBits(0, 0, 3)), 32'h7);
    checkOutput("cts_hold_busy", 32'(busy_v[0]), 32'h0);
    checkOutput("cts_hold_fifo", 32'(empty_v[0]), 32'h0);
    cts_n = 1'b0;
    applyStimulus(1);
    checkOutput("cts_start_tx",   32'(cap_v[3][0]), 32'h0);
    checkOutput("cts_start_busy", 32'(busy_v[0]), 32'h1);
    applyStimulus(4);
    cts_n = 1'b1;
    applyStimulus(6);
    checkOutput("cts_frame_7E", 32'(capBits(0, 3, 11)), 32'(expFrame(8'h7E, 1'b1, 1'b0, 1)));
    applyStimulus(1);
    checkOutput("cts_done", done_cnt[0] - base_done[0], 1);
    cts_n = 1'b0;

    // Fill FIFO while disabled, overflow, then drain
    enable = 1'b0;
    for (int i = 0; i < 8; i++) pushByte(4'b0001, 8'(8'h10 + i));
    checkOutput("fill_full",  32'(full_v[0]),  32'h1);
    checkOutput("fill_ready", 32'(ready_v[0]), 32'h0);
    pushByte(4'b0001, 8'h18);
    checkOutput("ovf_full",  32'(full_v[0]),  32'h1);
    checkOutput("ovf_empty", 32'(empty_v[0]), 32'h0);
    enable = 1'b1;
    cap_n = 0;
    snapDone();
    applyStimulus(89);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("burst_frame%0d", i), 32'(capBits(0, 11 * i, 11)),
                  32'(expFrame(8'(8'h10 + i), 1'b1, 1'b0, 1)));
    checkOutput("burst_done",  done_cnt[0] - base_done[0], 8);
    checkOutput("burst_empty", 32'(empty_v[0]), 32'h1);
    cap_n = 0;
    applyStimulus(2);
    checkOutput("ovf_dropped_tx",   32'(capBits(0, 0, 2)), 32'h3);
    checkOutput("ovf_dropped_busy", 32'(busy_v[0]), 32'h0);

    // Reset during the 4th data bit
    pushByte(4'b0001, 8'h33);
    pushByte(4'b0001, 8'h44);
    cap_n = 0;
    applyStimulus(5);
    checkOutput("mid_bit3", 32'(tx_v[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_tx",    32'(tx_v[0]),    32'h1);
    checkOutput("arst_busy",  32'(busy_v[0]),  32'h0);
    checkOutput("arst_empty", 32'(empty_v[0]), 32'h1);
    checkOutput("arst_full",  32'(full_v[0]),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cap_n = 0;
    snapDone();
    applyStimulus(13);
    checkOutput("post_rst_tx",    32'(capBits(0, 0, 13)), 32'h1FFF);
    checkOutput("post_rst_busy",  32'(busy_v[0]), 32'h0);
    checkOutput("post_rst_done",  done_cnt[0] - base_done[0], 0);
    checkOutput("post_rst_empty", 32'(empty_v[0]), 32'h1);
    checkOutput("post_rst_irq",   32'(irq_v[0]), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
